// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the select through channels 0..3, samples
// the mux output once per channel and publishes the four samples as one snapshot.
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       m,
  output logic       c0,
  output logic       c1,
  output logic       busy,
  output logic       done,
  output logic [3:0] snap,
  output logic       chg
);

  if (DWELL < 1) begin : g_bad_dwell
    $error("mux_scan_ctrl: DWELL must be at least 1");
  end

  localparam int             CW       = $clog2(DWELL) + 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [1:0]    ch_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    shadow_q;
  logic [3:0]    snap_q;
  logic          busy_q;
  logic          done_q;
  logic          chg_q;
  logic [3:0]    shadow_d;

  // Shadow with the current channel's sample merged in; on channel 3 this is the new snapshot.
  always_comb begin
    shadow_d       = shadow_q;
    shadow_d[ch_q] = m;
  end

  // Scan state machine with registered select, status and snapshot outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= 4'd0;
      snap_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          chg_q  <= 1'b0;
          ch_q   <= 2'd0;
          if (start) begin
            state_q <= S_SCAN;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_SCAN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            shadow_q <= shadow_d;
            if (ch_q == 2'd3) begin
              // Whole snapshot and change flag land on the same edge as done.
              ch_q    <= 2'd0;
              snap_q  <= shadow_d;
              chg_q   <= (shadow_d != snap_q);
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              ch_q  <= ch_q + 2'd1;
              cnt_q <= CNT_INIT;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          chg_q  <= 1'b0;
          ch_q   <= 2'd0;
          if (cont || start) begin
            state_q <= S_SCAN;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ch_q    <= 2'd0;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          chg_q   <= 1'b0;
        end
      endcase
    end
  end

  assign c0   = ch_q[0];
  assign c1   = ch_q[1];
  assign busy = busy_q;
  assign done = done_q;
  assign snap = snap_q;
  assign chg  = chg_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two instances (DWELL=2 and DWELL=1), each
// behind a behavioural 4:1 mux driven by bench-held x values.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, cont_a, m_a, c0_a, c1_a, busy_a, done_a, chg_a;
  logic       start_b, cont_b, m_b, c0_b, c1_b, busy_b, done_b, chg_b;
  logic [3:0] snap_a, snap_b;
  logic [3:0] xa, xb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign m_a = xa[{c1_a, c0_a}];
  assign m_b = xb[{c1_b, c0_b}];

  mux_scan_ctrl #(.DWELL(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cont(cont_a), .m(m_a),
    .c0(c0_a), .c1(c1_a), .busy(busy_a), .done(done_a), .snap(snap_a), .chg(chg_a)
  );

  mux_scan_ctrl #(.DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cont(cont_b), .m(m_b),
    .c0(c0_b), .c1(c1_b), .busy(busy_b), .done(done_b), .snap(snap_b), .chg(chg_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called just after the accepting edge E0; ends just after edge E0+4*dwell.
  task automatic scan_body(input bit inst_b, input int dwell, input logic [3:0] exp_snap,
                           input logic exp_chg, input bit poke, input string tag);
    for (int k = 0; k < 4 * dwell; k++) begin
      check_eq({tag, "_sel"},  inst_b ? {c1_b, c0_b} : {c1_a, c0_a}, k / dwell);
      check_eq({tag, "_busy"}, inst_b ? busy_b : busy_a, 1);
      check_eq({tag, "_done"}, inst_b ? done_b : done_a, 0);
      if (poke && k < 4 * dwell - 1) start_a = (k % 2 == 0);
      else if (poke) start_a = 1'b0;
      tick();
    end
    check_eq({tag, "_dn_done"}, inst_b ? done_b : done_a, 1);
    check_eq({tag, "_dn_busy"}, inst_b ? busy_b : busy_a, 0);
    check_eq({tag, "_dn_sel"},  inst_b ? {c1_b, c0_b} : {c1_a, c0_a}, 0);
    check_eq({tag, "_snap"},    inst_b ? snap_b : snap_a, exp_snap);
    check_eq({tag, "_chg"},     inst_b ? chg_b : chg_a, exp_chg);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; cont_a = 1'b0; start_b = 1'b0; cont_b = 1'b0;
    xa = 4'b1011;   // x0=1 x1=1 x2=0 x3=1
    xb = 4'b0010;   // x0=0 x1=1 x2=0 x3=0
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      check_eq("rst_sel",  {c1_a, c0_a}, 0);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_done", done_a, 0);
      check_eq("rst_chg",  chg_a, 0);
      check_eq("rst_snap", snap_a, 0);
      tick();
    end

    // Single scan, DWELL=2
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    scan_body(1'b0, 2, 4'b1011, 1'b1, 1'b0, "one");
    tick();
    check_eq("one_after_done", done_a, 0);
    check_eq("one_after_chg",  chg_a, 0);
    check_eq("one_after_busy", busy_a, 0);
    check_eq("one_hold_snap",  snap_a, 4'b1011);

    // Continuous mode: unchanged inputs, then x2 flips to 1
    cont_a  = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    scan_body(1'b0, 2, 4'b1011, 1'b0, 1'b0, "cont1");
    tick();
    scan_body(1'b0, 2, 4'b1011, 1'b0, 1'b0, "cont2");
    tick();
    xa = 4'b1111;
    check_eq("cont3_old_snap", snap_a, 4'b1011);
    scan_body(1'b0, 2, 4'b1111, 1'b1, 1'b0, "cont3");
    cont_a = 1'b0;
    tick();
    check_eq("cont_stop_busy", busy_a, 0);
    check_eq("cont_stop_done", done_a, 0);
    tick();
    check_eq("cont_stop_busy2", busy_a, 0);

    // DWELL=1 instance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    scan_body(1'b1, 1, 4'b0010, 1'b1, 1'b0, "d1");
    tick();
    check_eq("d1_after_done", done_b, 0);
    check_eq("d1_after_busy", busy_b, 0);

    // start pulses during SCAN must not restart or shorten the scan
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    scan_body(1'b0, 2, 4'b1111, 1'b0, 1'b1, "poke");
    tick();
    check_eq("poke_no_restart", busy_a, 0);
    check_eq("poke_single_done", done_a, 0);

    // Reset mid-scan aborts everything
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    check_eq("abort_busy_pre", busy_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_sel",  {c1_a, c0_a}, 0);
    check_eq("abort_busy", busy_a, 0);
    check_eq("abort_done", done_a, 0);
    check_eq("abort_chg",  chg_a, 0);
    check_eq("abort_snap", snap_a, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("abort_no_done", done_a, 0);
      check_eq("abort_idle",    busy_a, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits around the 4:1 `mux` block. It drives the mux select lines `c0`/`c1` through channels 0..3, holds each select for a programmable dwell, and samples the mux output `m` once per channel. It publishes the four sampled values atomically as a 4-bit snapshot, with a start/busy/done handshake and an optional continuous-scan mode. Only the mux output is sampled; the block never touches `x0..x3`.

## Interface
Parameters:
- `DWELL`, default 2: cycles each select value is held before `m` is sampled; legal range ≥ 1 (0 is illegal, elaboration error).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: scan request, sampled in IDLE and DONE.
- `cont` in 1: continuous mode; when 1, a new scan starts automatically after each DONE.
- `m` in 1: mux output, from `mux.m`.
- `c0` out 1: select LSB, to `mux.c0`. Channel index is {c1,c0}, and index n selects xn.
- `c1` out 1: select MSB, to `mux.c1`.
- `busy` out 1: high while scanning.
- `done` out 1: one-cycle pulse when `snap` updates.
- `snap` out 4: bit n is the value of `m` sampled while channel n was selected.
- `chg` out 1: pulses with `done` when the new `snap` differs from the previous one.

## Operation
- Reset, on the edge where `rst`=1:
  - State is IDLE.
  - `c0`=`c1`=0, `busy`=0, `done`=0, `chg`=0, `snap`=0.
  - Internal shadow register = 0 and dwell counter = 0.
- State machine: IDLE → SCAN → DONE → (SCAN | IDLE).
- IDLE:
  - Select is 0; `busy`=0.
  - If `start`=1, go to SCAN with ch=0 and cnt=DWELL-1.
- SCAN (`busy`=1):
  - If cnt≠0, decrement cnt.
  - If cnt=0, write shadow[ch] ← `m`.
    - If ch=3: ch wraps to 0, `snap` ← shadow with the new bit merged, go to DONE.
    - Otherwise: ch ← ch+1, cnt ← DWELL-1.
  - `start` is ignored in SCAN.
- DONE (lasts exactly one cycle):
  - `done`=1 and `busy`=0; select is 0.
  - `chg`=1 iff the new `snap` ≠ the previous `snap`.
  - Next state is SCAN (ch=0, cnt=DWELL-1) if `cont`=1 or `start`=1; otherwise IDLE.
- `snap` changes only on DONE entry and holds its value through later scans until the next DONE.
- Dwell counter width: ceil(log2(DWELL))+1 bits; no overflow is possible.
- Reset during SCAN or DONE aborts the scan: the partial shadow is discarded (cleared), `snap` clears, and no `done` is issued.

## Timing
- All outputs are registered; `c0`/`c1` come straight from flops.
- Let E0 be the edge that accepts `start`.
  - Channel n is driven from E0+n·DWELL to E0+(n+1)·DWELL.
  - `m` for channel n is sampled at edge E0+(n+1)·DWELL.
  - The mux is combinational, so the sampled value reflects channel n.
- `done`/`chg` are high during the cycle after edge E0+4·DWELL.
- Start-to-done latency is 4·DWELL+1 cycles; `busy` is high for exactly 4·DWELL cycles.
- Back-to-back scans (`cont`=1): period is 4·DWELL+1 cycles; `busy` drops for exactly the one DONE cycle.
- A `start` pulse held across DONE causes one restart; it does not queue.

## Test plan
- Reset, then idle 10 cycles with `start`=0 → `c0`=`c1`=0, `busy`=`done`=`chg`=0, `snap`=0.
- Bench holds x0..x3 = 1,1,0,1 behind a behavioural 4:1 mux; pulse `start` with DWELL=2 →
  - `{c1,c0}` runs 0,0,1,1,2,2,3,3.
  - `done` pulses 9 cycles after E0.
  - `snap`=4'b1011 and `chg`=1.
- `cont`=1 with the inputs unchanged → a `done` pulse every 9 cycles, `snap` stays 4'b1011, `chg`=0 after the first scan. Then flip x2 to 1 mid-run → the next `done` carries `snap`=4'b1111 and `chg`=1.
- DWELL=1 with x = 0,1,0,0 →
  - Select advances every cycle.
  - `done` 5 cycles after `start`.
  - `snap`=4'b0010.
- Pulse `start` repeatedly during SCAN → no restart, single `done`, latency unchanged.
- Assert `rst` at cycle 3 of a scan → the next cycle shows all outputs 0 and state IDLE; no `done` is ever produced for the aborted scan.
